// File: rtl/trap_seq_pkg.sv
// Shared types and constants for the trap entry / MRET exit sequencer.
`ifndef XLEN
`define XLEN 32
`endif

package trap_seq_pkg;

    localparam int unsigned XLEN_W = `XLEN;

    // Cause codes, numbered as in the core's trap_causes table
    localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_INSTR_ACCESS   = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    // Request source ranks: lower index wins. Exec is oldest in program
    // order; MRET beats a fetch fault because that fetch is wrong-path.
    localparam int unsigned PRIO_EXEC  = 0;
    localparam int unsigned PRIO_MRET  = 1;
    localparam int unsigned PRIO_FETCH = 2;
    localparam int unsigned NUM_SRC    = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WRITE,
        REDIRECT
    } trap_seq_state_t;

    typedef enum logic {
        REQ_TRAP = 1'b0,
        REQ_MRET = 1'b1
    } trap_kind_t;

    typedef struct packed {
        trap_kind_t        kind;
        logic [XLEN_W-1:0] pc;
        logic [XLEN_W-1:0] tval;
        logic [3:0]        cause;
    } trap_req_t;

endpackage

// File: rtl/trap_req_select.sv
// Combinational priority pick over exec exception, MRET and fetch exception.
module trap_req_select
    import trap_seq_pkg::*;
(
    input  logic              fetch_exc_valid,
    input  logic [XLEN_W-1:0] fetch_exc_pc,
    input  logic [XLEN_W-1:0] fetch_exc_tval,
    input  logic [3:0]        fetch_exc_cause,
    input  logic              exec_exc_valid,
    input  logic [XLEN_W-1:0] exec_exc_pc,
    input  logic [XLEN_W-1:0] exec_exc_tval,
    input  logic [3:0]        exec_exc_cause,
    input  logic              mret_valid,
    output logic              req_valid,
    output trap_req_t         req
);

    logic [NUM_SRC-1:0] src_valid;

    assign src_valid[PRIO_EXEC]  = exec_exc_valid;
    assign src_valid[PRIO_MRET]  = mret_valid;
    assign src_valid[PRIO_FETCH] = fetch_exc_valid;
    assign req_valid = |src_valid;

    // Pick the highest-ranked pending source; MRET carries no payload
    always_comb begin
        req      = '0;
        req.kind = REQ_TRAP;
        if (src_valid[PRIO_EXEC]) begin
            req.pc    = exec_exc_pc;
            req.tval  = exec_exc_tval;
            req.cause = exec_exc_cause;
        end else if (src_valid[PRIO_MRET]) begin
            req.kind = REQ_MRET;
        end else if (src_valid[PRIO_FETCH]) begin
            req.pc    = fetch_exc_pc;
            req.tval  = fetch_exc_tval;
            req.cause = fetch_exc_cause;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET exit sequencer: drain, CSR trap write, single PC redirect.
module trap_sequencer
    import trap_seq_pkg::*;
#(
    parameter int unsigned XLEN          = XLEN_W,
    parameter int unsigned DRAIN_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_exc_valid,
    input  logic [XLEN-1:0] fetch_exc_pc,
    input  logic [XLEN-1:0] fetch_exc_tval,
    input  logic [3:0]      fetch_exc_cause,
    input  logic            exec_exc_valid,
    input  logic [XLEN-1:0] exec_exc_pc,
    input  logic [XLEN-1:0] exec_exc_tval,
    input  logic [3:0]      exec_exc_cause,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic            pipeline_idle,
    output logic            flush,
    output logic            csr_wr_en,
    output logic [XLEN-1:0] csr_wr_mepc,
    output logic [XLEN-1:0] csr_wr_mcause,
    output logic [XLEN-1:0] csr_wr_mtval,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    localparam int unsigned CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    trap_seq_state_t state;
    trap_req_t       req;
    trap_req_t       sel_req;
    logic            sel_valid;
    logic            accept;
    logic [CNT_W-1:0] drain_cnt;
    logic            timeout_expired;
    logic            drain_done;
    logic            unused_bits;

    trap_req_select u_select (
        .fetch_exc_valid (fetch_exc_valid),
        .fetch_exc_pc    (fetch_exc_pc),
        .fetch_exc_tval  (fetch_exc_tval),
        .fetch_exc_cause (fetch_exc_cause),
        .exec_exc_valid  (exec_exc_valid),
        .exec_exc_pc     (exec_exc_pc),
        .exec_exc_tval   (exec_exc_tval),
        .exec_exc_cause  (exec_exc_cause),
        .mret_valid      (mret_valid),
        .req_valid       (sel_valid),
        .req             (sel_req)
    );

    // Inputs only matter in IDLE; while busy they belong to flushed instructions
    assign accept = (state == IDLE) && sel_valid;

    // Timeout flag: raised on the last permitted DRAIN cycle
    assign timeout_expired = (DRAIN_TIMEOUT != 0) && (state == DRAIN)
                             && (drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1));
    assign drain_done = pipeline_idle || timeout_expired;

    assign busy  = (state != IDLE);
    // Combinational term covers the accept cycle so the faulting instruction never commits
    assign flush = busy || accept;

    assign csr_wr_mepc   = {req.pc[XLEN-1:1], 1'b0};
    assign csr_wr_mcause = XLEN'(req.cause);
    assign csr_wr_mtval  = req.tval;

    assign unused_bits = ^{csr_mtvec[1:0], csr_mepc[1:0], req.pc[0]};

    // Sequencer FSM with registered strobes and redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req            <= '0;
            csr_wr_en      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            drain_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req       <= sel_req;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        if (req.kind == REQ_TRAP) begin
                            redirect_pc <= {csr_mtvec[XLEN-1:2], 2'b00};
                            csr_wr_en   <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            redirect_pc    <= {csr_mepc[XLEN-1:2], 2'b00};
                            redirect_valid <= 1'b1;
                            state          <= REDIRECT;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    csr_wr_en      <= 1'b0;
                    redirect_valid <= 1'b1;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: vector table plus reset corner cases.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_exc_valid = 1'b0;
    logic [31:0] fetch_exc_pc = '0;
    logic [31:0] fetch_exc_tval = '0;
    logic [3:0]  fetch_exc_cause = '0;
    logic        exec_exc_valid = 1'b0;
    logic [31:0] exec_exc_pc = '0;
    logic [31:0] exec_exc_tval = '0;
    logic [3:0]  exec_exc_cause = '0;
    logic        mret_valid = 1'b0;
    logic [31:0] csr_mtvec = '0;
    logic [31:0] csr_mepc = '0;
    logic        pipeline_idle = 1'b1;
    logic        redirect_ready = 1'b0;
    logic        flush, csr_wr_en, redirect_valid, busy;
    logic [31:0] csr_wr_mepc, csr_wr_mcause, csr_wr_mtval, redirect_pc;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    trap_sequencer #(.XLEN(32), .DRAIN_TIMEOUT(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_exc_valid (fetch_exc_valid),
        .fetch_exc_pc    (fetch_exc_pc),
        .fetch_exc_tval  (fetch_exc_tval),
        .fetch_exc_cause (fetch_exc_cause),
        .exec_exc_valid  (exec_exc_valid),
        .exec_exc_pc     (exec_exc_pc),
        .exec_exc_tval   (exec_exc_tval),
        .exec_exc_cause  (exec_exc_cause),
        .mret_valid      (mret_valid),
        .csr_mtvec       (csr_mtvec),
        .csr_mepc        (csr_mepc),
        .pipeline_idle   (pipeline_idle),
        .flush           (flush),
        .csr_wr_en       (csr_wr_en),
        .csr_wr_mepc     (csr_wr_mepc),
        .csr_wr_mcause   (csr_wr_mcause),
        .csr_wr_mtval    (csr_wr_mtval),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_ready  (redirect_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
    } wr_t;

    typedef struct {
        logic        ev;
        logic [31:0] epc;
        logic [31:0] etval;
        logic [3:0]  ecause;
        logic        mv;
        logic        fv;
        logic [31:0] fpc;
        logic [31:0] ftval;
        logic [3:0]  fcause;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        idle;
        int unsigned delay;
        logic        exp_wr;
        logic [31:0] exp_mepc;
        logic [31:0] exp_mcause;
        logic [31:0] exp_mtval;
        logic [31:0] exp_rpc;
        int unsigned exp_lat;
    } vec_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops expected CSR writes and redirects as the DUT emits them
    always @(negedge clk) begin
        wr_t w;
        if (csr_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_csr_write", csr_wr_en, 1'b0);
            end else begin
                w = wr_q.pop_front();
                chk("csr_wr_mepc", csr_wr_mepc, w.mepc);
                chk("csr_wr_mcause", csr_wr_mcause, w.mcause);
                chk("csr_wr_mtval", csr_wr_mtval, w.mtval);
            end
        end
        if (redirect_valid === 1'b1 && redirect_ready === 1'b1) begin
            if (rd_q.size() == 0)
                chk("unexpected_redirect", redirect_valid, 1'b0);
            else
                chk("redirect_pc", redirect_pc, rd_q.pop_front());
        end
        if (prev_hold && redirect_valid === 1'b1)
            chk("redirect_pc_stable", redirect_pc, prev_pc);
        prev_hold <= (redirect_valid === 1'b1) && (redirect_ready !== 1'b1);
        prev_pc   <= redirect_pc;
    end

    task automatic clear_reqs();
        exec_exc_valid  = 1'b0;
        mret_valid      = 1'b0;
        fetch_exc_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int unsigned k;
        int unsigned wr_k;
        logic        got_rv;
        wr_t         w;
        @(posedge clk); #1;
        exec_exc_valid  = v.ev;
        exec_exc_pc     = v.epc;
        exec_exc_tval   = v.etval;
        exec_exc_cause  = v.ecause;
        mret_valid      = v.mv;
        fetch_exc_valid = v.fv;
        fetch_exc_pc    = v.fpc;
        fetch_exc_tval  = v.ftval;
        fetch_exc_cause = v.fcause;
        csr_mtvec       = v.mtvec;
        csr_mepc        = v.mepc;
        pipeline_idle   = v.idle;
        redirect_ready  = 1'b0;
        if (v.exp_wr) begin
            w.mepc   = v.exp_mepc;
            w.mcause = v.exp_mcause;
            w.mtval  = v.exp_mtval;
            wr_q.push_back(w);
        end
        rd_q.push_back(v.exp_rpc);
        @(negedge clk);
        chk("flush_accept", flush, 1'b1);
        chk("busy_accept", busy, 1'b0);
        // junk requests while busy must be ignored
        @(posedge clk); #1;
        exec_exc_valid = 1'b1;
        exec_exc_pc    = 32'hBAD0;
        exec_exc_tval  = '1;
        exec_exc_cause = 4'd5;
        mret_valid     = 1'b1;
        fetch_exc_valid = 1'b1;
        k = 0; wr_k = 0; got_rv = 1'b0;
        while (!got_rv && k < 40) begin
            k++;
            @(negedge clk);
            chk("flush_busy", flush, 1'b1);
            chk("busy_busy", busy, 1'b1);
            if (csr_wr_en === 1'b1) wr_k = k;
            if (redirect_valid === 1'b1) got_rv = 1'b1;
        end
        chk("redirect_latency", k, v.exp_lat);
        chk("write_cycle", wr_k, v.exp_wr ? v.exp_lat - 1 : 0);
        for (int unsigned d = 1; d < v.delay; d++) begin
            @(negedge clk);
            chk("redirect_hold", redirect_valid, 1'b1);
            chk("flush_hold", flush, 1'b1);
        end
        @(posedge clk); #1;
        clear_reqs();
        redirect_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_flush", flush, 1'b0);
        chk("idle_redirect_valid", redirect_valid, 1'b0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
    endtask

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;
        vecs[0] = '{1'b1, 32'h14, 32'hF11FD073, 4'd2, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0,
                    32'h73, 32'h0, 1'b1, 1, 1'b1, 32'h14, 32'h2, 32'hF11FD073, 32'h70, 3};
        vecs[1] = '{1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1, 32'h4, 32'hFFF0C17F, 4'd2,
                    32'h32, 32'h0, 1'b1, 2, 1'b1, 32'h4, 32'h2, 32'hFFF0C17F, 32'h30, 3};
        vecs[2] = '{1'b1, 32'h103, 32'hDEAD, 4'd7, 1'b1, 1'b1, 32'h900, 32'h1234, 4'd1,
                    32'h200, 32'h500, 1'b1, 1, 1'b1, 32'h102, 32'h7, 32'hDEAD, 32'h200, 3};
        vecs[3] = '{1'b0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0,
                    32'h73, 32'h3C, 1'b1, 5, 1'b0, 32'h0, 32'h0, 32'h0, 32'h3C, 2};
        vecs[4] = '{1'b0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b1, 32'h8, 32'h77, 4'd1,
                    32'h10, 32'h47, 1'b1, 1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h44, 2};
        vecs[5] = '{1'b1, 32'h20, 32'h1, 4'd2, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0,
                    32'h80, 32'h0, 1'b0, 3, 1'b1, 32'h20, 32'h2, 32'h1, 32'h80, 17};
        vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0,
                    32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, 32'hFFFFFFFE, 32'hF, 32'h0, 32'hFFFFFFFC, 3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_flush", flush, 1'b0);
        chk("reset_csr_wr_en", csr_wr_en, 1'b0);
        chk("reset_redirect_valid", redirect_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        chk("reset_mepc", csr_wr_mepc, 32'h0);
        chk("reset_mcause", csr_wr_mcause, 32'h0);
        chk("reset_mtval", csr_wr_mtval, 32'h0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // reset while in WRITE: the in-flight strobe is whole, then nothing follows
        @(posedge clk); #1;
        exec_exc_valid = 1'b1; exec_exc_pc = 32'h40; exec_exc_tval = 32'h55; exec_exc_cause = 4'd2;
        csr_mtvec = 32'h100; pipeline_idle = 1'b1;
        w.mepc = 32'h40; w.mcause = 32'h2; w.mtval = 32'h55;
        wr_q.push_back(w);
        @(posedge clk); #1;
        clear_reqs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_write_strobe", csr_wr_en, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_write_flush", flush, 1'b0);
        chk("rst_write_csr_wr_en", csr_wr_en, 1'b0);
        chk("rst_write_redirect_valid", redirect_valid, 1'b0);
        chk("rst_write_busy", busy, 1'b0);
        @(negedge clk);
        chk("rst_write_no_redirect", redirect_valid, 1'b0);
        chk("rst_write_wr_q", wr_q.size(), 0);

        // reset while in REDIRECT with ready low
        @(posedge clk); #1;
        mret_valid = 1'b1; csr_mepc = 32'h80;
        @(posedge clk); #1;
        clear_reqs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_redir_valid_before", redirect_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_redir_flush", flush, 1'b0);
        chk("rst_redir_csr_wr_en", csr_wr_en, 1'b0);
        chk("rst_redir_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redir_redirect_pc", redirect_pc, 32'h0);
        chk("rst_redir_busy", busy, 1'b0);

        // normal trap afterwards
        run_txn(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
